// File: rtl/hqm_AW_pkg.sv
// Shared HQM assertion-path package: common helper functions and the
// state encoding used by the ordering-FIFO drain stage.
package hqm_AW_pkg;

    // Ceiling log2, used to size pointers from a depth.
    function automatic int AW_logb2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        FLOW,
        HOL,
        TMO
    } hqm_ofifo_drain_state_t;

endpackage

// File: rtl/hqm_assertion_skid2.sv
// Two-entry in-order staging buffer.
// Ports: push/push_data write the tail, pop retires the head shown on
// pop_data, cnt gives occupancy 0..2. The caller never pushes when full
// or pops when empty.
module hqm_assertion_skid2
    import hqm_AW_pkg::*;
#(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [DWIDTH-1:0] pop_data,
    output logic [1:0]        cnt
);

    localparam int DEPTH = 2;
    localparam int PW    = AW_logb2(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/hqm_assertion_ofifo_drain.sv
// Drain stage behind the assertion ordering FIFO: pops valid heads into a
// 2-entry buffer feeding a valid/ready consumer, tracks head-of-line
// stalls (hol_cnt, sticky hol_timeout) and counts drained entries.
// Ports: fifo_* = FIFO pop side; out_* = consumer handshake;
// hol_limit/clr = control; hol_timeout/hol_cnt/drain_cnt = status.
module hqm_assertion_ofifo_drain
    import hqm_AW_pkg::*;
#(
    parameter int DWIDTH   = 16,
    parameter int CNTWIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fifo_empty,
    input  logic                fifo_pop_v,
    input  logic [DWIDTH-1:0]   fifo_pop_data,
    output logic                fifo_pop,
    output logic                out_v,
    output logic [DWIDTH-1:0]   out_data,
    input  logic                out_ready,
    input  logic [CNTWIDTH-1:0] hol_limit,
    input  logic                clr,
    output logic                hol_timeout,
    output logic [CNTWIDTH-1:0] hol_cnt,
    output logic [CNTWIDTH-1:0] drain_cnt
);

    hqm_ofifo_drain_state_t state_q;
    hqm_ofifo_drain_state_t state_d;

    logic [1:0] buf_cnt;
    logic       xfer;
    logic       stall;
    logic       hol_hit;

    // Pop depends only on local occupancy, never on out_ready.
    assign fifo_pop = fifo_pop_v & (buf_cnt != 2'd2);
    assign out_v    = (buf_cnt != 2'd0);
    assign xfer     = out_v & out_ready;

    // A stall is a hole at the head; back-pressure is not a stall.
    assign stall    = ~fifo_empty & ~fifo_pop_v;
    assign hol_hit  = (hol_limit != '0) && (hol_cnt == hol_limit);

    hqm_assertion_skid2 #(
        .DWIDTH (DWIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_pop),
        .push_data (fifo_pop_data),
        .pop       (xfer),
        .pop_data  (out_data),
        .cnt       (buf_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fifo_pop_v)       state_d = FLOW;
                else if (!fifo_empty) state_d = HOL;
            end
            FLOW: begin
                if (fifo_empty)       state_d = IDLE;
                else if (!fifo_pop_v) state_d = HOL;
            end
            // Filling the hole wins over a same-cycle limit hit.
            HOL: begin
                if (fifo_pop_v)       state_d = FLOW;
                else if (fifo_empty)  state_d = IDLE;
                else if (hol_hit)     state_d = TMO;
            end
            TMO: state_d = TMO;
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hol_cnt     <= '0;
            hol_timeout <= 1'b0;
            drain_cnt   <= '0;
        end else if (clr) begin
            hol_cnt     <= '0;
            hol_timeout <= 1'b0;
            drain_cnt   <= '0;
        end else begin
            if (fifo_pop) begin
                drain_cnt <= drain_cnt + 1'b1;
            end
            if (state_q == HOL && stall && hol_hit) begin
                hol_timeout <= 1'b1;
            end
            // hol_cnt freezes in TMO and at the limit-hit cycle.
            if (state_q != TMO) begin
                if (!stall) begin
                    hol_cnt <= '0;
                end else if (!(state_q == HOL && hol_hit) && !(&hol_cnt)) begin
                    hol_cnt <= hol_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hqm_assertion_ofifo_drain.sv
// Self-checking bench for hqm_assertion_ofifo_drain: directed scenarios
// plus random traffic compared against a queue-based reference model.
module tb_hqm_assertion_ofifo_drain;

    logic        clk;
    logic        rst_n;
    logic        fifo_empty;
    logic        fifo_pop_v;
    logic [15:0] fifo_pop_data;
    logic        fifo_pop;
    logic        out_v;
    logic [15:0] out_data;
    logic        out_ready;
    logic [15:0] hol_limit;
    logic        clr;
    logic        hol_timeout;
    logic [15:0] hol_cnt;
    logic [15:0] drain_cnt;

    int checks;
    int failures;

    // Reference model state
    logic [15:0] q[$];
    logic [15:0] m_drain;
    logic [15:0] m_hc;
    logic        m_tmo;

    hqm_assertion_ofifo_drain #(
        .DWIDTH   (16),
        .CNTWIDTH (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_empty    (fifo_empty),
        .fifo_pop_v    (fifo_pop_v),
        .fifo_pop_data (fifo_pop_data),
        .fifo_pop      (fifo_pop),
        .out_v         (out_v),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .hol_limit     (hol_limit),
        .clr           (clr),
        .hol_timeout   (hol_timeout),
        .hol_cnt       (hol_cnt),
        .drain_cnt     (drain_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_drain = '0;
        m_hc    = '0;
        m_tmo   = 1'b0;
    endtask

    task automatic chk_outputs();
        chk("out_v", out_v, q.size() != 0);
        if (q.size() != 0) chk("out_data", out_data, q[0]);
        chk("hol_cnt", hol_cnt, m_hc);
        chk("hol_timeout", hol_timeout, m_tmo);
        chk("drain_cnt", drain_cnt, m_drain);
    endtask

    // One clock cycle; entered and left at posedge+1.
    task automatic step(input logic e, input logic pv, input logic [15:0] d,
                        input logic rdy, input logic c);
        logic exp_pop;
        logic stall;
        fifo_empty    = e;
        fifo_pop_v    = pv;
        fifo_pop_data = d;
        out_ready     = rdy;
        clr           = c;
        #1;
        exp_pop = pv && (q.size() < 2);
        chk("fifo_pop", fifo_pop, exp_pop);
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (exp_pop) q.push_back(d);
        stall = !e && !pv;
        if (c) begin
            m_drain = '0;
            m_hc    = '0;
            m_tmo   = 1'b0;
        end else begin
            if (exp_pop) m_drain = m_drain + 16'd1;
            if (!m_tmo) begin
                if (!stall) m_hc = '0;
                else if (hol_limit != 0 && m_hc == hol_limit) m_tmo = 1'b1;
                else if (m_hc != 16'hFFFF) m_hc = m_hc + 16'd1;
            end
        end
        @(posedge clk);
        #1;
        chk_outputs();
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        fifo_empty    = 1'b1;
        fifo_pop_v    = 1'b0;
        fifo_pop_data = '0;
        out_ready     = 1'b0;
        hol_limit     = 16'd10;
        clr           = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fifo_pop", fifo_pop, 1'b0);
        chk("rst_out_v", out_v, 1'b0);
        chk("rst_out_data", out_data, 16'h0);
        chk("rst_hol_cnt", hol_cnt, 16'h0);
        chk("rst_timeout", hol_timeout, 1'b0);
        chk("rst_drain", drain_cnt, 16'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Continuous flow A,B,C
        step(0, 1, 16'hA0A0, 1, 0);
        step(0, 1, 16'hB1B1, 1, 0);
        step(0, 1, 16'hC2C2, 1, 0);
        step(1, 0, 16'h0, 1, 0);
        chk("flow_drain3", drain_cnt, 16'd3);
        step(1, 0, 16'h0, 1, 0);

        // Back-pressure
        step(0, 1, 16'h1111, 0, 0);
        step(0, 1, 16'h2222, 0, 0);
        step(0, 1, 16'h3333, 0, 0);
        step(0, 1, 16'h3333, 0, 0);
        chk("bp_hold_head", out_data, 16'h1111);
        step(0, 1, 16'h3333, 1, 0);
        step(0, 1, 16'h3333, 0, 0);
        chk("bp_resume_drain", drain_cnt, 16'd6);
        step(1, 0, 16'h0, 1, 0);
        step(1, 0, 16'h0, 1, 0);

        // Hole of 5 cycles under a limit of 10
        hol_limit = 16'd10;
        repeat (5) step(0, 0, 16'h0, 1, 0);
        chk("hole_cnt5", hol_cnt, 16'd5);
        chk("hole_no_tmo", hol_timeout, 1'b0);
        step(0, 1, 16'h4444, 1, 0);
        chk("hole_cleared", hol_cnt, 16'd0);

        // Timeout at limit 4, sticky after the hole fills, then clr
        hol_limit = 16'd4;
        repeat (7) step(0, 0, 16'h0, 1, 0);
        chk("tmo_set", hol_timeout, 1'b1);
        step(0, 1, 16'h5555, 1, 0);
        step(0, 1, 16'h6666, 1, 0);
        chk("tmo_sticky", hol_timeout, 1'b1);
        step(0, 1, 16'h7777, 0, 1);
        chk("clr_tmo", hol_timeout, 1'b0);
        chk("clr_drain", drain_cnt, 16'd0);
        step(1, 0, 16'h0, 1, 0);
        step(1, 0, 16'h0, 1, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic e;
            logic pv;
            if ($urandom_range(0, 99) == 0) hol_limit = 16'($urandom_range(0, 6));
            e  = ($urandom_range(0, 3) == 0);
            pv = !e && ($urandom_range(0, 2) != 0);
            step(e, pv, 16'($urandom), 1'($urandom), $urandom_range(0, 63) == 0);
        end

        // Saturation with timeout disabled
        step(0, 0, 16'h0, 1, 1);
        hol_limit = 16'd0;
        for (int i = 0; i < 65600; i++) step(0, 0, 16'h0, 1, 0);
        chk("sat_cnt", hol_cnt, 16'hFFFF);
        chk("sat_no_tmo", hol_timeout, 1'b0);
        step(1, 0, 16'h0, 1, 0);

        // Reset with two entries staged
        step(0, 1, 16'h8888, 0, 0);
        step(0, 1, 16'h9999, 0, 0);
        chk("pre_rst_full", out_v, 1'b1);
        fifo_pop_v = 1'b0;
        fifo_empty = 1'b1;
        rst_n      = 1'b0;
        model_reset();
        #1;
        chk("arst_out_v", out_v, 1'b0);
        chk("arst_drain", drain_cnt, 16'd0);
        chk("arst_out_data", out_data, 16'h0);
        chk("arst_fifo_pop", fifo_pop, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 1, 16'hABCD, 1, 0);
        step(1, 0, 16'h0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
